// File: rtl/reg_write_arb_if.sv
// reg_write_arb_if: request/grant and register-file write bundle for reg_write_arb.
// Rev 1.0 - initial release.
`default_nettype none

interface reg_write_arb_if #(
    parameter int W = 8,
    parameter int A = 4
);
    logic [2:0]     req;
    logic [3*A-1:0] req_addr;
    logic [3*W-1:0] req_data;
    logic [2:0]     gnt;
    logic           write_en;
    logic [A-1:0]   waddr;
    logic [W-1:0]   wr_data;
    logic           conflict;
    logic           busy;

    modport master (
        output req, req_addr, req_data,
        input  gnt, write_en, waddr, wr_data, conflict, busy
    );

    modport slave (
        input  req, req_addr, req_data,
        output gnt, write_en, waddr, wr_data, conflict, busy
    );
endinterface

`default_nettype wire

// File: rtl/reg_write_arb.sv
// reg_write_arb: three-way register-file write arbiter (ALU/MEM/IMM), one registered grant per cycle.
// Macro REG_WRITE_ARB_RR_EN selects round-robin; default is fixed priority IMM > MEM > ALU.  Rev 1.0.
`default_nettype none

module reg_write_arb #(
    parameter int W = 8,
    parameter int A = 4
) (
    input  logic             clk,
    input  logic             rst,
    reg_write_arb_if.slave   bus
);
    logic [2:0]   gnt_q, gnt_d;
    logic         we_q, we_d;
    logic [A-1:0] waddr_q, waddr_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic         conflict_q, conflict_d;
    logic [1:0]   ptr_q, ptr_d;

    logic [2:0]   eligible;
    logic [1:0]   win;

    // Masking the current grant stops a held request being issued twice.
    assign eligible = bus.req & ~gnt_q;

    always_comb begin
        win = 2'd0;
`ifdef REG_WRITE_ARB_RR_EN
        case (ptr_q)
            2'd1:    win = eligible[1] ? 2'd1 : (eligible[2] ? 2'd2 : 2'd0);
            2'd2:    win = eligible[2] ? 2'd2 : (eligible[0] ? 2'd0 : 2'd1);
            default: win = eligible[0] ? 2'd0 : (eligible[1] ? 2'd1 : 2'd2);
        endcase
`else
        if (eligible[2])      win = 2'd2;
        else if (eligible[1]) win = 2'd1;
        else                  win = 2'd0;
`endif
    end

    always_comb begin
        gnt_d      = 3'b000;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        conflict_d = 1'b0;
        ptr_d      = ptr_q;
        if (|eligible) begin
            gnt_d      = 3'b001 << win;
            we_d       = 1'b1;
            waddr_d    = bus.req_addr[int'(win)*A +: A];
            wdata_d    = bus.req_data[int'(win)*W +: W];
            conflict_d = (eligible[0] & eligible[1]) | (eligible[0] & eligible[2])
                       | (eligible[1] & eligible[2]);
`ifdef REG_WRITE_ARB_RR_EN
            ptr_d      = (win == 2'd2) ? 2'd0 : win + 2'd1;
`else
            ptr_d      = 2'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q      <= 3'b000;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            conflict_q <= 1'b0;
            ptr_q      <= 2'd0;
        end else begin
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            conflict_q <= conflict_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.write_en = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wr_data  = wdata_q;
    assign bus.conflict = conflict_q;
    assign bus.busy     = |eligible;
endmodule

`default_nettype wire
